cordic_vectoring: RTL and testbench

Iterative, sequential vectoring-mode CORDIC. It is the inverse direction of the unrolled rotation-mode cosine path. It takes a fixed-point vector (x, y) and returns its angle atan2(y, x) and its magnitude. It uses one micro-rotation per clock, sits behind the float-to-fixed unpacker, and feeds the fixed-to-float packer with valid/ready handshakes on both sides.

---
 rtl/cordic_pkg.sv | 34 +++
 rtl/cordic_vec_stage.sv | 34 +++
 rtl/cordic_vectoring.sv | 144 ++++++++++++++
 tb/tb_cordic_vectoring.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and types for the vectoring-mode CORDIC.
//   ATAN[i]  : atan(2^-i) in Q.24, rounded to nearest
//   PI_HALF  : pi/2 in Q.24
//   PI       : pi in Q.24
//   KINV     : 1/K = 0.607253 in Q.24, used only when CORDIC_GAIN_COMP_EN is defined
//   cordic_vec_state_t : engine FSM states; SCALE exists only with CORDIC_GAIN_COMP_EN
package cordic_pkg;

  localparam logic [31:0] ATAN [32] = '{
    32'h00C90FDB, 32'h0076B19C, 32'h003EB6EC, 32'h001FD5BB,
    32'h000FFAAE, 32'h0007FF55, 32'h0003FFEB, 32'h0001FFFD,
    32'h00010000, 32'h00008000, 32'h00004000, 32'h00002000,
    32'h00001000, 32'h00000800, 32'h00000400, 32'h00000200,
    32'h00000100, 32'h00000080, 32'h00000040, 32'h00000020,
    32'h00000010, 32'h00000008, 32'h00000004, 32'h00000002,
    32'h00000001, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
  };

  localparam logic [31:0] PI_HALF = 32'h01921FB5;
  localparam logic [31:0] PI      = 32'h03243F6A;
  localparam logic [31:0] KINV    = 32'h009B74EE;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ITER,
`ifdef CORDIC_GAIN_COMP_EN
    SCALE,
`endif
    DONE
  } cordic_vec_state_t;

endpackage

// File: rtl/cordic_vec_stage.sv
// One vectoring micro-rotation, purely combinational. Drives y toward zero:
// the sign of y picks the rotation direction, and the angle accumulator moves
// by +/- atan_i accordingly. Both new x and new y are formed from the old ones.
//   x, y       : signed Q4.WIDTH vector
//   z          : signed Q3.WIDTH angle accumulator
//   i          : iteration index (shift amount)
//   atan_i     : atan(2^-i) in the z format
//   x_next, y_next, z_next : rotated vector and updated angle
module cordic_vec_stage #(
  parameter int WIDTH = 24
) (
  input  logic signed [WIDTH+3:0] x,
  input  logic signed [WIDTH+3:0] y,
  input  logic signed [WIDTH+2:0] z,
  input  logic        [4:0]       i,
  input  logic signed [WIDTH+2:0] atan_i,
  output logic signed [WIDTH+3:0] x_next,
  output logic signed [WIDTH+3:0] y_next,
  output logic signed [WIDTH+2:0] z_next
);

  logic signed [WIDTH+3:0] x_sh;
  logic signed [WIDTH+3:0] y_sh;
  logic                    y_neg;

  assign x_sh  = x >>> i;
  assign y_sh  = y >>> i;
  assign y_neg = y[WIDTH+3];

  assign x_next = y_neg ? x - y_sh   : x + y_sh;
  assign y_next = y_neg ? y + x_sh   : y - x_sh;
  assign z_next = y_neg ? z - atan_i : z + atan_i;

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: returns atan2(y, x) and the vector magnitude,
// one micro-rotation per clock, valid/ready on both sides, no overlap of jobs.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid, in_ready  : input handshake (in_ready high exactly in IDLE)
//   x_in, y_in          : signed Q2.WIDTH vector
//   out_valid, out_ready: output handshake (out_valid high exactly in DONE)
//   angle               : signed Q3.WIDTH radians, (-pi, +pi]
//   magnitude           : Q4.WIDTH; raw (times 1.64676) unless CORDIC_GAIN_COMP_EN
// Optional feature macro: CORDIC_GAIN_COMP_EN adds a one-cycle SCALE state that
// multiplies by KINV so the magnitude comes out gain-corrected.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int ITERS = 19
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH+1:0] x_in,
  input  logic signed [WIDTH+1:0] y_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH+2:0] angle,
  output logic signed [WIDTH+3:0] magnitude
);

  localparam int DW = WIDTH + 4;
  localparam int ZW = WIDTH + 3;
  localparam logic signed [ZW-1:0] Z_PI_HALF = ZW'(PI_HALF);
  localparam logic        [4:0]    LAST_ITER = 5'(ITERS - 1);

  cordic_vec_state_t state, state_next;

  logic signed [DW-1:0] x, y, x_next, y_next;
  logic signed [ZW-1:0] z, z_next, atan_i;
  logic        [4:0]    iter;
  // All-zero input has no defined angle; the iterations would otherwise
  // accumulate the sum of the whole ATAN table, so the result is forced to 0.
  logic                 is_zero;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign atan_i    = ZW'(ATAN[iter]);

  cordic_vec_stage #(.WIDTH(WIDTH)) u_stage (
    .x      (x),
    .y      (y),
    .z      (z),
    .i      (iter),
    .atan_i (atan_i),
    .x_next (x_next),
    .y_next (y_next),
    .z_next (z_next)
  );

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = DW + WIDTH + 1;
  localparam logic signed [WIDTH:0] KINV_S = (WIDTH+1)'(KINV);
  logic signed [PW-1:0] prod;
  assign prod = PW'(x) * PW'(KINV_S);
`endif

  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = PRE;
      PRE:  state_next = ITER;
      ITER: if (iter == LAST_ITER) begin
`ifdef CORDIC_GAIN_COMP_EN
        state_next = SCALE;
`else
        state_next = DONE;
`endif
      end
`ifdef CORDIC_GAIN_COMP_EN
      SCALE: state_next = DONE;
`endif
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      iter      <= '0;
      is_zero   <= 1'b0;
      angle     <= '0;
      magnitude <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (in_valid) begin
          x       <= {{2{x_in[WIDTH+1]}}, x_in};
          y       <= {{2{y_in[WIDTH+1]}}, y_in};
          is_zero <= (x_in == '0) && (y_in == '0);
        end
        // Fold left-half-plane vectors into the right half so the iterations
        // only ever have to cover +/- pi/2. y == 0 with x < 0 lands on +pi.
        PRE: begin
          if (x[DW-1] && !y[DW-1]) begin
            x <= y;
            y <= -x;
            z <= Z_PI_HALF;
          end else if (x[DW-1]) begin
            x <= -y;
            y <= x;
            z <= -Z_PI_HALF;
          end else begin
            z <= '0;
          end
          iter <= '0;
        end
        ITER: begin
          x    <= x_next;
          y    <= y_next;
          z    <= z_next;
          iter <= iter + 5'd1;
`ifndef CORDIC_GAIN_COMP_EN
          if (iter == LAST_ITER) begin
            angle     <= is_zero ? '0 : z_next;
            magnitude <= x_next;
          end
`endif
        end
`ifdef CORDIC_GAIN_COMP_EN
        SCALE: begin
          angle     <= is_zero ? '0 : z;
          magnitude <= DW'(prod >>> WIDTH);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: the driver pushes the expected angle
// and magnitude (from real-valued atan2/sqrt) when a vector is accepted; a
// monitor pops and compares whenever a result is handed over.
`timescale 1ns/1ps
module tb_cordic_vectoring;

  localparam int  WIDTH = 24;
  localparam int  ITERS = 19;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT = ITERS + 3;
`else
  localparam int  LAT = ITERS + 2;
`endif
  localparam real ONE      = 16777216.0;
  localparam int  TOL      = 64;
  // Random vectors also carry shift-truncation error on top of the residual
  // angle of the last micro-rotation, so they get a little headroom.
  localparam int  TOL_RAND = 96;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    out_ready = 1'b1;
  logic signed [WIDTH+1:0] x_in = '0;
  logic signed [WIDTH+1:0] y_in = '0;
  logic                    in_ready;
  logic                    out_valid;
  logic signed [WIDTH+2:0] angle;
  logic signed [WIDTH+3:0] magnitude;

  cordic_vectoring #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .angle     (angle),
    .magnitude (magnitude)
  );

  always #5 clk = ~clk;

  typedef struct {
    real ang;
    real mag;
    int  tol;
  } exp_t;

  exp_t   exp_q[$];
  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  longint acc_cyc = 0;
  bit     prev_valid = 1'b0;

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic bit near(input longint act, input real req, input int tol);
    real d;
    d = real'(act) - req;
    if (d < 0.0) d = -d;
    return d <= real'(tol);
  endfunction

  function automatic longint iabs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: true atan2 and Euclidean length; raw magnitude carries the
  // CORDIC gain prod(sqrt(1 + 4^-i)) over the iterations actually performed.
  function automatic exp_t model(input longint xv, input longint yv, input int tol);
    exp_t e;
    real  g, p;
    e.tol = tol;
    if (xv == 0 && yv == 0) e.ang = 0.0;
    else e.ang = $atan2(real'(yv), real'(xv)) * ONE;
    e.mag = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
`ifndef CORDIC_GAIN_COMP_EN
    g = 1.0;
    p = 1.0;
    for (int i = 0; i < ITERS; i++) begin
      g = g * $sqrt(1.0 + p);
      p = p * 0.25;
    end
    e.mag = e.mag * g;
`else
    g = 1.0;
    p = 1.0;
`endif
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: latency on the rising edge of out_valid, data on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (out_valid && !prev_valid)
        check("latency", (cyc - acc_cyc) == LAT, cyc - acc_cyc, LAT);
      prev_valid = out_valid;
      if (out_valid && out_ready) begin
        check("result_expected", exp_q.size() > 0, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("angle", near(longint'(angle), e.ang, e.tol), longint'(angle), $rtoi(e.ang));
          check("magnitude", near(longint'(magnitude), e.mag, e.tol), longint'(magnitude),
                $rtoi(e.mag));
        end
      end
    end
  end

  // Caller is just after a rising edge; returns just after the accept edge.
  task automatic send(input longint xv, input longint yv, input int tol, output int waited);
    in_valid = 1'b1;
    x_in     = (WIDTH+2)'(xv);
    y_in     = (WIDTH+2)'(yv);
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", in_ready, waited, 200);
    if (in_ready) exp_q.push_back(model(xv, yv, tol));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", exp_q.size() == 0, exp_q.size(), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           w, n;
    bit           stale;
    longint       a0, m0, xv, yv;
    longint       one;
    one = longint'(1) << WIDTH;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready == 1'b1, in_ready, 1);
    check("reset_out_valid", out_valid == 1'b0, out_valid, 0);
    check("reset_angle", angle == '0, angle, 0);
    check("reset_magnitude", magnitude == '0, magnitude, 0);
    @(posedge clk);
    #1;

    // Directed vectors, including the boundary cases.
    send(one, 0, TOL, w);
    send(one, one, TOL, w);
    send(-one, 0, TOL, w);
    send(0, -one, TOL, w);
    send(0, 0, TOL, w);
    send(-2 * one, -2 * one, TOL, w);
    send(-2 * one, 0, TOL, w);
    drain();

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    send(one / 2, -3 * one / 4, TOL, w);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", out_valid == 1'b1, out_valid, 1);
    a0 = longint'(angle);
    m0 = longint'(magnitude);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid == 1'b1, out_valid, 1);
      check("bp_hold_angle", longint'(angle) == a0, longint'(angle), a0);
      check("bp_hold_magnitude", longint'(magnitude) == m0, longint'(magnitude), m0);
      check("bp_in_ready_low", in_ready == 1'b0, in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_handshake", in_ready == 1'b1, in_ready, 1);
    send(-one, one / 3, TOL, w);
    check("back_to_back_accept", w == 0, w, 0);
    drain();

    // Reset during ITER with i = 7: aborted, no result ever appears.
    send(one, one / 5, TOL, w);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_in_ready", in_ready == 1'b1, in_ready, 1);
    check("abort_out_valid", out_valid == 1'b0, out_valid, 0);
    check("abort_angle", angle == '0, angle, 0);
    check("abort_magnitude", magnitude == '0, magnitude, 0);
    stale = 1'b0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("no_stale_result", !stale, stale, 0);
    @(posedge clk);
    #1;

    // Random vectors with length of at least about 0.5.
    for (int k = 0; k < 24; k++) begin
      do begin
        xv = longint'($urandom_range(0, (1 << (WIDTH + 2)) - 1)) - (longint'(1) << (WIDTH + 1));
        yv = longint'($urandom_range(0, (1 << (WIDTH + 2)) - 1)) - (longint'(1) << (WIDTH + 1));
      end while (iabs(xv) < one / 2 && iabs(yv) < one / 2);
      send(xv, yv, TOL_RAND, w);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
